gpio_modport: RTL and testbench



---
 rtl/gpio_modport.sv | 52 +++++
 tb/tb_gpio_modport.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gpio_modport.sv
// gpio_modport: clocked GPIO responder on the DUT side of the GPIO agent bus.
// It returns registered data on gpio_in[H-1:0], inverted per bit by a mask.
// It returns per-bit change flags for either edge on gpio_in[GPIO_W-1:H].
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous, active-high reset; clears all state
//   gpio_out - agent outputs: [H-1:0] data, [GPIO_W-1:H] invert mask
//   gpio_in  - agent inputs:  [H-1:0] loopback data, [GPIO_W-1:H] change flags
//
// GPIO_W must be even and at least 2.
module gpio_modport #(
  parameter int unsigned GPIO_W = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_in
);

  localparam int unsigned H = GPIO_W / 2;

  logic [H-1:0]      w_data;
  logic [H-1:0]      w_mask;
  logic [H-1:0]      w_loop;
  logic [H-1:0]      w_chg;

  logic [H-1:0]      r_prev;
  logic [GPIO_W-1:0] r_gpio_in;

  // Split the agent bus into data and invert mask.
  assign w_data = gpio_out[H-1:0];
  assign w_mask = gpio_out[GPIO_W-1:H];

  // The mask only shapes the loopback. Change detection uses the raw data.
  assign w_loop = w_data ^ w_mask;
  assign w_chg  = w_data ^ r_prev;

  // Previous data and response registers. A reset discards the change history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_gpio_in <= '0;
    end else begin
      r_prev    <= w_data;
      r_gpio_in <= {w_chg, w_loop};
    end
  end

  assign gpio_in = r_gpio_in;

endmodule

// File: tb/tb_gpio_modport.sv
// tb_gpio_modport: directed self-checking bench for gpio_modport.
// It drives a 1024-bit instance and an 8-bit instance from shared clock and reset.
module tb_gpio_modport;

  logic              clk;
  logic              rst;
  logic [1023:0]     gpio_out;
  logic [1023:0]     gpio_in;
  logic [7:0]        gpio_out8;
  logic [7:0]        gpio_in8;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_modport #(.GPIO_W(1024)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in)
  );

  gpio_modport #(.GPIO_W(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .gpio_out (gpio_out8),
    .gpio_in  (gpio_in8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare an observed value with an expected value and report the first differing bit.
  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int bad;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      bad = -1;
      for (int i = 1023; i >= 0; i--)
        if (obs[i] !== exp[i]) bad = i;
      $display("FAIL %s: first bad bit %0d got %b required %b (low128 got %h required %h)",
               tag, bad, obs[bad], exp[bad], obs[127:0], exp[127:0]);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    for (int i = 0; i < 32; i++) gpio_out[32*i +: 32] = $urandom;
    gpio_out8 = 8'($urandom);
  endtask

  logic [511:0] a5;
  logic [511:0] m55;
  logic [511:0] ones;

  initial begin
    a5   = {64{8'hA5}};
    m55  = {128{4'h5}};
    ones = '1;

    // Reset with random bus contents. The outputs must be 0 from the start.
    rst = 1'b1;
    rand_bus();
    #2;
    check("rst_async", gpio_in, '0);
    check("rst_async8", 1024'(gpio_in8), '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_hold", gpio_in, '0);
      check("rst_hold8", 1024'(gpio_in8), '0);
      rand_bus();
    end

    // Plain loopback. Release reset between edges and hold A5 for 3 edges.
    rst       = 1'b0;
    gpio_out  = {512'b0, a5};
    gpio_out8 = {4'h0, 4'hA};
    tick();
    check("loop_e1", gpio_in, {a5, a5});
    check("loop8_e1", 1024'(gpio_in8), 1024'({4'hA, 4'hA}));
    tick();
    check("loop_e2", gpio_in, {512'b0, a5});
    check("loop8_e2", 1024'(gpio_in8), 1024'({4'h0, 4'hA}));
    tick();
    check("loop_e3", gpio_in, {512'b0, a5});

    // Inversion. Data goes all-ones and the mask alternates.
    gpio_out  = {m55, ones};
    gpio_out8 = {4'h5, 4'hF};
    tick();
    check("inv_e1", gpio_in, {~a5, {128{4'hA}}});
    check("inv8_e1", 1024'(gpio_in8), 1024'({4'h5, 4'hA}));
    tick();
    check("inv_e2", gpio_in, {512'b0, {128{4'hA}}});
    // A change to the mask alone must not raise any change flag.
    gpio_out  = {512'b0, ones};
    gpio_out8 = {4'h0, 4'hF};
    tick();
    check("mask_only", gpio_in, {512'b0, ones});
    check("mask_only8", 1024'(gpio_in8), 1024'({4'h0, 4'hF}));

    // Toggle stress: start from 0, then toggle bit 0 every cycle and set bit 7 once at cycle 10.
    gpio_out = '0;
    tick();
    check("tog_clear", gpio_in, {ones, 512'b0});
    for (int c = 0; c < 20; c++) begin
      gpio_out[0] = ~gpio_out[0];
      if (c == 10) gpio_out[7] = 1'b1;
      tick();
      check("tog_b0", 1024'(gpio_in[512]), 1024'(1'b1));
      check("tog_b7", 1024'(gpio_in[519]), 1024'(c == 10));
      check("tog_loop0", 1024'(gpio_in[0]), 1024'(gpio_out[0]));
    end

    // Mid-operation reset: pulse rst for 1.5 cycles between edges while holding 0xFF.
    gpio_out  = {1016'b0, 8'hFF};
    gpio_out8 = 8'h0F;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_async", gpio_in, '0);
    check("mid_rst_async8", 1024'(gpio_in8), '0);
    tick();
    check("mid_rst_edge", gpio_in, '0);
    #5;
    rst = 1'b0;
    #1;
    check("mid_rst_rel", gpio_in, '0);
    tick();
    check("mid_rst_after", gpio_in, {504'b0, 8'hFF, 504'b0, 8'hFF});
    check("mid_rst_after8", 1024'(gpio_in8), 1024'(8'hFF));
    tick();
    check("mid_rst_after2", gpio_in, {512'b0, 504'b0, 8'hFF});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
